// File: rtl/pxs_logo_capture.sv
// Captures a WIDTH_LOGO x HEIGHT_LOGO window of one video frame into a 1-bit bitmap (ink=1).
// The stream passes through with one cycle of latency; the bitmap has a synchronous read port.
module pxs_logo_capture #(
    parameter int         WIDTH_LOGO  = 64,
    parameter int         HEIGHT_LOGO = 64,
    parameter int         X0          = 288,
    parameter int         Y0          = 208,
    parameter logic [2:0] INK         = 3'b000
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic [25:0] RGBStr_i,
    output logic [25:0] RGBStr_o,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [12:0] wr_count,
    input  logic [11:0] rd_addr,
    output logic        rd_data
);

    localparam int AW_X  = $clog2(WIDTH_LOGO);
    localparam int AW_Y  = $clog2(HEIGHT_LOGO);
    localparam int AW    = AW_X + AW_Y;
    localparam int DEPTH = WIDTH_LOGO * HEIGHT_LOGO;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;

    // Stream word layout: {HS, VS, XC[9:0], YC[9:0], Active, RGB[2:0]}
    logic [9:0] xc;
    logic [9:0] yc;
    logic       active;
    logic [2:0] rgb;

    assign xc     = RGBStr_i[23:14];
    assign yc     = RGBStr_i[13:4];
    assign active = RGBStr_i[3];
    assign rgb    = RGBStr_i[2:0];

    logic          in_win;
    logic          sof;
    logic          last_px;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign in_win  = active
                   && (xc >= 10'(X0)) && (xc < 10'(X0 + WIDTH_LOGO))
                   && (yc >= 10'(Y0)) && (yc < 10'(Y0 + HEIGHT_LOGO));
    assign sof     = active && (xc == 10'd0) && (yc == 10'd0);
    assign last_px = (xc == 10'(X0 + WIDTH_LOGO - 1)) && (yc == 10'(Y0 + HEIGHT_LOGO - 1));
    assign wr_addr = {AW_Y'(yc - 10'(Y0)), AW_X'(xc - 10'(X0))};

    // The sof pixel itself may be written while still ARMED.
    assign wr_en = in_win && ((state == CAPTURE) || ((state == ARMED) && sof));

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
        end else begin
            if (wr_en) begin
                wr_count <= wr_count + 13'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ARMED;
                        busy     <= 1'b1;
                        wr_count <= '0;
                    end
                end
                ARMED, CAPTURE: begin
                    if (wr_en && last_px) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (sof) begin
                        state <= CAPTURE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= ARMED;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        wr_count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            RGBStr_o <= '0;
        end else begin
            RGBStr_o <= RGBStr_i;
        end
    end

    // Bitmap array carries no reset so it maps onto a single block RAM.
    logic mem [DEPTH];

    always_ff @(posedge px_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= (rgb == INK);
        end
    end

    // Read-before-write: a same-cycle write to rd_addr is seen one cycle later.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 1'b0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_pxs_logo_capture.sv
// Bench for pxs_logo_capture: compressed frames (only the pixels that matter) checked
// cycle-by-cycle against a frame-level model, plus literal expectations.
module tb_pxs_logo_capture;

    localparam int X0 = 288;
    localparam int Y0 = 208;
    localparam int W  = 64;
    localparam int H  = 64;

    logic        px_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [25:0] rgb_str_i = '0;
    logic [25:0] rgb_str_o;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [12:0] wr_count;
    logic [11:0] rd_addr = '0;
    logic        rd_data;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit hold_rd0 = 1'b0;
    int sweep = 0;
    int done_rises = 0;
    logic done_prev = 1'b0;

    pxs_logo_capture #(
        .WIDTH_LOGO(W), .HEIGHT_LOGO(H), .X0(X0), .Y0(Y0), .INK(3'b000)
    ) dut (
        .px_clk(px_clk),
        .rst_n(rst_n),
        .RGBStr_i(rgb_str_i),
        .RGBStr_o(rgb_str_o),
        .start(start),
        .busy(busy),
        .done(done),
        .wr_count(wr_count),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 px_clk = ~px_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Frame-level model: phase 0 idle, 1 waiting for frame start, 2 capturing, 3 finished.
    bit          m_mem [4096];
    bit          m_known [4096];
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [25:0] m_o = '0;
    bit          m_rd = 1'b0;
    bit          m_rd_known = 1'b1;

    always @(posedge px_clk or negedge rst_n) begin : model
        int x, y, a;
        bit act, win, sof_px;
        logic [2:0] c;
        if (!rst_n) begin
            m_phase    = 0;
            m_cnt      = 0;
            m_o        = '0;
            m_rd       = 1'b0;
            m_rd_known = 1'b1;
        end else begin
            x   = int'(rgb_str_i[23:14]);
            y   = int'(rgb_str_i[13:4]);
            act = rgb_str_i[3];
            c   = rgb_str_i[2:0];
            m_o        = rgb_str_i;
            m_rd       = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            win    = act && x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H;
            sof_px = act && x == 0 && y == 0;
            if ((m_phase == 2 || (m_phase == 1 && sof_px)) && win) begin
                a = (y - Y0) * W + (x - X0);
                m_mem[a]   = (c == 3'b000);
                m_known[a] = 1'b1;
                m_cnt++;
                m_phase = (x == X0 + W - 1 && y == Y0 + H - 1) ? 3 : 2;
            end else if (m_phase == 1 && sof_px) begin
                m_phase = 2;
            end else if ((m_phase == 0 || m_phase == 3) && start) begin
                m_phase = 1;
                m_cnt   = 0;
            end
        end
    end

    always @(negedge px_clk) begin
        if (rst_n && cmp_en) begin
            check("passthru", rgb_str_o, m_o);
            check("busy", busy, (m_phase == 1 || m_phase == 2));
            check("done", done, (m_phase == 3));
            check("wr_count", wr_count, m_cnt);
            if (m_rd_known) check("rd_data", rd_data, m_rd);
        end
        if (done && !done_prev) done_rises++;
        done_prev = done;
    end

    function automatic logic [2:0] pix_rgb(input int mode, input int x, input int y);
        case (mode)
            0:       return ((((x - X0) ^ (y - Y0)) & 1) != 0) ? 3'b000 : 3'b111;
            1:       return (x == 300 && y == 210) ? 3'b000 : 3'b001;
            default: return 3'((x + y) % 8);
        endcase
    endfunction

    task automatic send_pix(input int x, input int y, input bit act, input logic [2:0] c, input bit st);
        rgb_str_i = {1'(x & 1), 1'(y & 1), 10'(x), 10'(y), act, c};
        start     = st;
        rd_addr   = hold_rd0 ? 12'd0 : 12'(sweep);
        sweep     = (sweep + 1) % 4096;
        @(posedge px_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        send_pix(5, 5, 1'b0, 3'b000, 1'b1);
    endtask

    task automatic read_check(input int r, input int c, input bit want, input string name);
        rd_addr = 12'(r * 64 + c);
        @(posedge px_clk);
        @(negedge px_clk);
        check(name, rd_data, want);
    endtask

    task automatic send_frame(input int mode, input int start_row, input int glitch_row,
                              input int abort_at, input bit expect_done);
        int n = 0;
        bit coll_pending = 1'b0;
        send_pix(0, 0, 1'b1, 3'b010, 1'b0);
        send_pix(10, 0, 1'b1, 3'b000, 1'b0);
        send_pix(X0 + 3, Y0 + 3, 1'b0, 3'b000, 1'b0);
        for (int y = Y0 - 1; y <= Y0 + H; y++) begin
            send_pix(X0 - 1, y, 1'b1, 3'b000, 1'b0);
            if (y >= Y0 && y < Y0 + H) begin
                for (int x = X0; x < X0 + W; x++) begin
                    if (expect_done && x == X0 + W - 1 && y == Y0 + H - 1) begin
                        check("busy_before_last", busy, 1);
                        check("done_before_last", done, 0);
                    end
                    send_pix(x, y, 1'b1, pix_rgb(mode, x, y), (y == start_row && x == X0));
                    n++;
                    if (coll_pending) begin
                        @(negedge px_clk);
                        check("rw_collision_new", rd_data, 1);
                        coll_pending = 1'b0;
                    end
                    if (hold_rd0 && x == X0 && y == Y0) begin
                        @(negedge px_clk);
                        check("rw_collision_old", rd_data, 0);
                        coll_pending = 1'b1;
                    end
                    if (y == glitch_row && x == X0) send_pix(0, 0, 1'b1, 3'b000, 1'b0);
                    if (expect_done && x == X0 + W - 1 && y == Y0 + H - 1) begin
                        @(negedge px_clk);
                        check("done_after_last", done, 1);
                        check("busy_after_last", busy, 0);
                        check("wr_count_final", wr_count, 4096);
                    end
                    if (abort_at != 0 && n == abort_at) begin
                        check("wr_count_before_reset", wr_count, 1000);
                        #2 rst_n = 1'b0;
                        #1;
                        check("async_rst_busy", busy, 0);
                        check("async_rst_done", done, 0);
                        check("async_rst_wr_count", wr_count, 0);
                        check("async_rst_rgb_o", rgb_str_o, 0);
                        check("async_rst_rd_data", rd_data, 0);
                        @(posedge px_clk);
                        @(posedge px_clk);
                        #1 rst_n = 1'b1;
                        return;
                    end
                end
            end
            send_pix(X0 + W, y, 1'b1, 3'b000, 1'b0);
        end
        send_pix(639, 479, 1'b1, 3'b000, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge px_clk);
        @(negedge px_clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_wr_count", wr_count, 0);
        check("reset_rgb_o", rgb_str_o, 0);
        check("reset_rd_data", rd_data, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge px_clk);
        #1;

        // No start: stream passes through, nothing armed.
        send_frame(2, -1, -1, 0, 1'b0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Start mid-frame arms; the following frame is captured.
        send_frame(0, Y0 + 5, -1, 0, 1'b0);
        check("armed_busy", busy, 1);
        check("armed_wr_count", wr_count, 0);
        send_frame(0, -1, -1, 0, 1'b1);
        read_check(0, 0, 0, "chk_0_0");
        read_check(0, 1, 1, "chk_0_1");
        read_check(1, 0, 1, "chk_1_0");
        read_check(63, 63, 0, "chk_63_63");
        read_check(5, 2, 1, "chk_5_2");

        // In DONE a whole frame passes without touching the bitmap.
        send_frame(2, -1, -1, 0, 1'b0);
        check("done_hold", done, 1);
        check("done_hold_count", wr_count, 4096);
        read_check(0, 1, 1, "nowrite_0_1");
        read_check(0, 0, 0, "nowrite_0_0");

        // Threshold, with a start pulse mid-capture that must be ignored.
        pulse_start();
        send_frame(1, Y0 + 10, -1, 0, 1'b1);
        read_check(2, 12, 1, "thr_2_12");
        read_check(2, 11, 0, "thr_2_11");
        read_check(0, 0, 0, "thr_0_0");
        read_check(63, 63, 0, "thr_63_63");

        // Read/write collision at address 0, plus a stray frame start mid-capture.
        pulse_start();
        hold_rd0 = 1'b1;
        send_frame(2, -1, Y0 + 20, 0, 1'b1);
        hold_rd0 = 1'b0;

        // Asynchronous reset at 1000 pixels, then a clean recapture.
        pulse_start();
        send_frame(0, -1, -1, 1000, 1'b0);
        check("post_reset_done", done, 0);
        pulse_start();
        send_frame(0, -1, -1, 0, 1'b1);
        read_check(5, 2, 1, "recap_5_2");
        read_check(7, 7, 0, "recap_7_7");
        check("done_rise_count", done_rises, 4);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
